// File: rtl/uart_rx_ctrl_param.sv
// Purpose: parametrised UART receiver (start confirm, LSB-first data, optional parity, 1/2 stop bits).
// Latency: rx_valid rises 1 clock after the last stop sample (OVERSAMPLE/2 + OVERSAMPLE*bits ticks after start).
// Backpressure: result held until rx_valid && rx_ready; a frame completing while still held is dropped (overrun_err pulse).
//
// Ports:
//   clock, reset     rising-edge clock, synchronous active-high reset
//   rx_en            receiver enable; low aborts an in-progress frame on the next tick
//   sample_tick      oversampling strobe, OVERSAMPLE pulses per bit period
//   rx_in            synchronised serial line, idle high
//   rx_data/rx_valid/rx_ready  received word with valid/ready handshake
//   parity_err, frame_err      status for the word currently in rx_data
//   overrun_err      one-cycle pulse when a completed frame is dropped
//   busy             receiver is inside a frame
module uart_rx_ctrl_param #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx_en,
  input  logic                 sample_tick,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic          ODD_PAR   = (PARITY_MODE == 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state, state_nx;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_flag;
  logic                 frm_flag;
  logic                 armed;

  logic abort;      // rx_en dropped mid-frame on a tick
  logic mid_bit;    // tick on which the current bit is sampled
  logic done;       // tick carrying the last stop sample

  // ---------------- state register ----------------
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_nx = state;
    if (sample_tick) begin
      if (state != IDLE && !rx_en) begin
        state_nx = IDLE;
      end else begin
        case (state)
          IDLE:    if (armed && rx_en && !rx_in) state_nx = START;
          START:   if (tick_cnt == HALF_LAST) state_nx = rx_in ? IDLE : DATA;
          DATA:    if (tick_cnt == FULL_LAST && bit_cnt == DATA_LAST)
                     state_nx = (PARITY_MODE != 0) ? PARITY : STOP;
          PARITY:  if (tick_cnt == FULL_LAST) state_nx = STOP;
          STOP:    if (tick_cnt == FULL_LAST && bit_cnt == STOP_LAST) state_nx = IDLE;
          default: state_nx = IDLE;
        endcase
      end
    end
  end

  // ---------------- state-decoded outputs/strobes ----------------
  always_comb begin
    busy    = (state != IDLE);
    abort   = sample_tick && busy && !rx_en;
    mid_bit = sample_tick && rx_en && (tick_cnt == FULL_LAST);
    done    = mid_bit && (state == STOP) && (bit_cnt == STOP_LAST);
  end

  // ---------------- counters and frame datapath ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_flag <= 1'b0;
      frm_flag <= 1'b0;
      armed    <= 1'b0;
    end else if (abort) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else if (sample_tick) begin
      case (state)
        IDLE: begin
          tick_cnt <= '0;
          bit_cnt  <= '0;
          // A line seen high arms the detector; a break after a frame must end first.
          if (rx_in) armed <= 1'b1;
          else if (armed && rx_en) armed <= 1'b0;
        end
        START: begin
          if (tick_cnt == HALF_LAST) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            par_flag <= 1'b0;
            frm_flag <= 1'b0;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        DATA: begin
          if (mid_bit) begin
            tick_cnt <= '0;
            // Shift in at the top so the first bit ends up at bit 0.
            shreg    <= {rx_in, shreg[DATA_BITS-1:1]};
            bit_cnt  <= (bit_cnt == DATA_LAST) ? '0 : bit_cnt + 1'b1;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (mid_bit) begin
            tick_cnt <= '0;
            par_flag <= ((^shreg) ^ rx_in) != ODD_PAR;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        STOP: begin
          if (mid_bit) begin
            tick_cnt <= '0;
            if (!rx_in) frm_flag <= 1'b1;
            bit_cnt  <= (bit_cnt == STOP_LAST) ? '0 : bit_cnt + 1'b1;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        default: begin
          tick_cnt <= '0;
          bit_cnt  <= '0;
        end
      endcase
    end
  end

  // ---------------- output handshake and overrun ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (done) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shreg;
          parity_err <= par_flag;
          // The final stop sample has not reached frm_flag yet.
          frame_err  <= frm_flag | ~rx_in;
          rx_valid   <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end
    end
  end

endmodule
